// File: rtl/pong_pkg.sv
// ============================================================================
// Module   : pong_pkg
// Purpose  : Shared types and constants for the pong text/score controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pong_pkg;

    localparam int BCD_W = 4;

    // Bit positions inside text_en, ordered {score, logo, rule, over}
    localparam int TXT_SCORE = 3;
    localparam int TXT_LOGO  = 2;
    localparam int TXT_RULE  = 1;
    localparam int TXT_OVER  = 0;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pong_text_ctrl_if.sv
// ============================================================================
// Module   : pong_text_ctrl_if
// Purpose  : Game-event inputs and overlay/status outputs of the controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pong_text_ctrl_if;
    import pong_pkg::*;

    logic             refr_tick;
    logic [1:0]       btn;
    logic             hit;
    logic             miss;
    logic [1:0]       ball;
    logic [BCD_W-1:0] dig0;
    logic [BCD_W-1:0] dig1;
    logic [3:0]       text_en;
    logic             gra_still;

    modport master (
        output refr_tick, btn, hit, miss,
        input  ball, dig0, dig1, text_en, gra_still
    );

    modport slave (
        input  refr_tick, btn, hit, miss,
        output ball, dig0, dig1, text_en, gra_still
    );

endinterface

`default_nettype wire

// File: rtl/pong_text_ctrl_bcd_counter2.sv
// ============================================================================
// Module   : bcd_counter2
// Purpose  : Two-digit BCD counter with clear, increment and 99 -> 00 wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_counter2
    import pong_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    output logic [BCD_W-1:0]      o_dig0,
    output logic [BCD_W-1:0]      o_dig1
);

    localparam logic [BCD_W-1:0] c_nine = BCD_W'(9);

    logic [BCD_W-1:0] r_dig0;
    logic [BCD_W-1:0] r_dig1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dig0 <= '0;
            r_dig1 <= '0;
        end else if (i_clr) begin
            r_dig0 <= '0;
            r_dig1 <= '0;
        end else if (i_inc) begin
            if (r_dig0 == c_nine) begin
                r_dig0 <= '0;
                r_dig1 <= (r_dig1 == c_nine) ? '0 : r_dig1 + 1'b1;
            end else begin
                r_dig0 <= r_dig0 + 1'b1;
            end
        end
    end

    assign o_dig0 = r_dig0;
    assign o_dig1 = r_dig1;

endmodule

`default_nettype wire

// File: rtl/pong_text_ctrl.sv
// ============================================================================
// Module   : pong_text_ctrl
// Purpose  : Pong game-flow FSM: score, balls left, hold timer, text enables.
//            Define PONG_RULE_TEXT_EN to show the rule region in NEWGAME.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_text_ctrl
    import pong_pkg::*;
#(
    parameter int BALLS       = 3,
    parameter int TIMER_TICKS = 120
) (
    input  wire logic      clk,
    input  wire logic      reset,
    pong_text_ctrl_if.slave bus
);

    localparam int          TIMER_W     = $clog2(TIMER_TICKS + 1);
    localparam logic [1:0]  c_ball_init = 2'(BALLS - 1);
    localparam logic [TIMER_W-1:0] c_timer_load = TIMER_W'(TIMER_TICKS);
`ifdef PONG_RULE_TEXT_EN
    localparam logic        c_rule_en   = 1'b1;
`else
    localparam logic        c_rule_en   = 1'b0;
`endif

    state_t               r_state;
    state_t               w_next_state;
    logic [1:0]           r_ball;
    logic [TIMER_W-1:0]   r_timer;
    logic                 w_timer_done;
    logic                 w_timer_load;
    logic                 w_ball_load;
    logic                 w_ball_dec;
    logic                 w_clr;
    logic                 w_inc;
    logic [3:0]           w_text_en;
    logic                 w_gra_still;
    logic                 w_btn_any;

    assign w_timer_done = (r_timer == '0);
    assign w_btn_any    = |bus.btn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_NEWGAME;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Load beats a same-cycle refresh tick so the hold always lasts the full count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_timer_load) begin
            r_timer <= c_timer_load;
        end else if (bus.refr_tick && !w_timer_done) begin
            r_timer <= r_timer - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ball <= c_ball_init;
        end else if (w_ball_load) begin
            r_ball <= c_ball_init;
        end else if (w_ball_dec) begin
            r_ball <= r_ball - 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_timer_load = 1'b0;
        w_ball_load  = 1'b0;
        w_ball_dec   = 1'b0;
        w_clr        = 1'b0;
        w_inc        = 1'b0;
        w_text_en    = '0;
        w_gra_still  = 1'b1;
        case (r_state)
            ST_NEWGAME: begin
                w_text_en[TXT_SCORE] = 1'b1;
                w_text_en[TXT_LOGO]  = 1'b1;
                w_text_en[TXT_RULE]  = c_rule_en;
                if (w_btn_any) begin
                    w_clr        = 1'b1;
                    w_ball_load  = 1'b1;
                    w_next_state = ST_PLAY;
                end
            end
            ST_PLAY: begin
                w_text_en[TXT_SCORE] = 1'b1;
                w_gra_still          = 1'b0;
                // A miss wins over a simultaneous hit: no point for a lost ball
                if (bus.miss) begin
                    w_timer_load = 1'b1;
                    if (r_ball != 2'd0) begin
                        w_ball_dec   = 1'b1;
                        w_next_state = ST_NEWBALL;
                    end else begin
                        w_next_state = ST_OVER;
                    end
                end else if (bus.hit) begin
                    w_inc = 1'b1;
                end
            end
            ST_NEWBALL: begin
                w_text_en[TXT_SCORE] = 1'b1;
                if (w_timer_done && w_btn_any) begin
                    w_next_state = ST_PLAY;
                end
            end
            ST_OVER: begin
                w_text_en[TXT_SCORE] = 1'b1;
                w_text_en[TXT_OVER]  = 1'b1;
                if (w_timer_done) begin
                    w_next_state = ST_NEWGAME;
                end
            end
            default: begin
                w_next_state = ST_NEWGAME;
            end
        endcase
    end

    bcd_counter2 u_score (
        .clk    (clk),
        .rst    (reset),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .o_dig0 (bus.dig0),
        .o_dig1 (bus.dig1)
    );

    assign bus.ball      = r_ball;
    assign bus.text_en   = w_text_en;
    assign bus.gra_still = w_gra_still;

endmodule

`default_nettype wire
